dma_flow_ctrl: RTL

Parametrised flow-control router for the DMA. It holds one 32-bit flow register per channel, written by byte lanes from the config block, and routes one of NUM_SRC peripheral slot/data/word-available lines to each channel. Peripheral inputs pass through a synchroniser, so asynchronous requesters are supported. A per-channel hold-off counter masks a channel's flow outputs for a programmable number of cycles after each transfer, covering peripherals that deassert their request late.

---
 rtl/dma_flow_ctrl_if.sv | 29 ++
 rtl/dma_flow_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/dma_flow_ctrl_if.sv
// Config and peripheral flow-control signals of the DMA flow router.
// The master side is the config block plus peripherals; the slave side is the router.
interface dma_flow_ctrl_if #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned NUM_SRC = 3
);
  logic [31:0]          write_data;
  logic [3:0]           ahb_byte;
  logic [NUM_CH-1:0]    ch_flow_sel;
  logic [NUM_SRC-1:0]   data_av;
  logic [NUM_SRC-1:0]   slot_av;
  logic [NUM_SRC-1:0]   word_av;
  logic [NUM_CH-1:0]    ch_xfer_done;
  logic [32*NUM_CH-1:0] flow_rdata;
  logic [NUM_CH-1:0]    ch_slot_av;
  logic [NUM_CH-1:0]    ch_data_av;
  logic [NUM_CH-1:0]    ch_word_av;
  logic [NUM_CH-1:0]    ch_holdoff;

  modport master (
    output write_data, ahb_byte, ch_flow_sel, data_av, slot_av, word_av, ch_xfer_done,
    input  flow_rdata, ch_slot_av, ch_data_av, ch_word_av, ch_holdoff
  );

  modport slave (
    input  write_data, ahb_byte, ch_flow_sel, data_av, slot_av, word_av, ch_xfer_done,
    output flow_rdata, ch_slot_av, ch_data_av, ch_word_av, ch_holdoff
  );
endinterface

// File: rtl/dma_flow_ctrl.sv
// Per-channel flow registers, peripheral line synchroniser, source routing
// and post-transfer hold-off masking for the DMA.
module dma_flow_ctrl #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           hclk,
  input logic           n_hreset,
  dma_flow_ctrl_if.slave bus
);

  localparam int unsigned SW = 3 * NUM_SRC;
  // Writable bits: selects [11:0], invert [12], hold-off length [23:16].
  localparam logic [31:0] WR_MASK = 32'h00FF_1FFF;

  logic [31:0]                     flow_q [NUM_CH];
  logic [7:0]                      hold_q [NUM_CH];
  logic [SYNC_STAGES-1:0][SW-1:0]  sync_q;
  logic [SW-1:0]                   sync_v;
  logic [15:0]                     data_ext;
  logic [15:0]                     slot_ext;
  logic [15:0]                     word_ext;
  logic [NUM_CH-1:0]               slot_r;
  logic [NUM_CH-1:0]               data_r;
  logic [NUM_CH-1:0]               word_r;
  logic [NUM_CH-1:0]               hold_r;
  logic [32*NUM_CH-1:0]            rdata_r;

  always_ff @(posedge hclk) begin
    if (!n_hreset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {bus.word_av, bus.slot_av, bus.data_av};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_v = sync_q[SYNC_STAGES-1];

  // Selects at or above NUM_SRC land on the padded '1' bits, giving tied-active lines.
  assign data_ext = {{(16-NUM_SRC){1'b1}}, sync_v[NUM_SRC-1:0]};
  assign slot_ext = {{(16-NUM_SRC){1'b1}}, sync_v[2*NUM_SRC-1:NUM_SRC]};
  assign word_ext = {{(16-NUM_SRC){1'b1}}, sync_v[3*NUM_SRC-1:2*NUM_SRC]};

  always_ff @(posedge hclk) begin
    if (!n_hreset) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        flow_q[n] <= '0;
        hold_q[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        // Load uses the pre-write HO, so a same-cycle write only affects the next load.
        if (bus.ch_xfer_done[n] && (flow_q[n][23:16] != 8'd0)) begin
          hold_q[n] <= flow_q[n][23:16];
        end else if (hold_q[n] != 8'd0) begin
          hold_q[n] <= hold_q[n] - 8'd1;
        end
        if (bus.ch_flow_sel[n]) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (bus.ahb_byte[k]) begin
              flow_q[n][8*k +: 8] <= bus.write_data[8*k +: 8] & WR_MASK[8*k +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    slot_r  = '0;
    data_r  = '0;
    word_r  = '0;
    hold_r  = '0;
    rdata_r = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      hold_r[n]           = (hold_q[n] != 8'd0);
      rdata_r[32*n +: 32] = flow_q[n];
      slot_r[n] = (slot_ext[flow_q[n][3:0]]  ^ flow_q[n][12]) & ~hold_r[n];
      data_r[n] = (data_ext[flow_q[n][7:4]]  ^ flow_q[n][12]) & ~hold_r[n];
      word_r[n] = (word_ext[flow_q[n][11:8]] ^ flow_q[n][12]) & ~hold_r[n];
    end
  end

  assign bus.ch_slot_av = slot_r;
  assign bus.ch_data_av = data_r;
  assign bus.ch_word_av = word_r;
  assign bus.ch_holdoff = hold_r;
  assign bus.flow_rdata = rdata_r;

endmodule
